// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, handshakes with instruction memory and
// feeds the IF/ID register. Define IF_STAGE_DELAY_SLOT_EN for MIPS delay-slot semantics.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        shouldStall,
  input  logic        shouldJumpOrBranch,
  input  logic [31:0] jumpOrBranchPc,
  output logic        imem_request,
  output logic [31:0] imem_address,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] id_pc_4,
  output logic [31:0] id_instruction,
  output logic [31:0] debug_pc
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_4_q, id_pc_4_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] hold_pc_4_q, hold_pc_4_d;
  logic [31:0] hold_instr_q, hold_instr_d;
`ifdef IF_STAGE_DELAY_SLOT_EN
  logic        pending_valid_q, pending_valid_d;
  logic [31:0] pending_target_q, pending_target_d;
`endif

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pcPlus4;

  // A stalled decode stage cannot own a redirect; the target is forced word-aligned.
  assign redirect = shouldJumpOrBranch & ~shouldStall;
  assign target   = jumpOrBranchPc & 32'hFFFF_FFFC;
  assign pcPlus4  = pc_q + 32'd4;

  assign imem_request   = (state_q == FETCH) & ~rst;
  assign imem_address   = pc_q;
  assign debug_pc       = pc_q;
  assign id_pc_4        = id_pc_4_q;
  assign id_instruction = id_instr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      pc_q         <= RESET_PC;
      id_pc_4_q    <= 32'd0;
      id_instr_q   <= NOP_WORD;
      hold_pc_4_q  <= 32'd0;
      hold_instr_q <= NOP_WORD;
`ifdef IF_STAGE_DELAY_SLOT_EN
      pending_valid_q  <= 1'b0;
      pending_target_q <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      id_pc_4_q    <= id_pc_4_d;
      id_instr_q   <= id_instr_d;
      hold_pc_4_q  <= hold_pc_4_d;
      hold_instr_q <= hold_instr_d;
`ifdef IF_STAGE_DELAY_SLOT_EN
      pending_valid_q  <= pending_valid_d;
      pending_target_q <= pending_target_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    id_pc_4_d    = id_pc_4_q;
    id_instr_d   = id_instr_q;
    hold_pc_4_d  = hold_pc_4_q;
    hold_instr_d = hold_instr_q;
`ifdef IF_STAGE_DELAY_SLOT_EN
    pending_valid_d  = pending_valid_q;
    pending_target_d = pending_target_q;
`endif
    case (state_q)
      FETCH: begin
        if (shouldStall) begin
          if (imem_ready) begin
            hold_pc_4_d  = pcPlus4;
            hold_instr_d = imem_data;
            state_d      = HOLD;
          end
`ifdef IF_STAGE_DELAY_SLOT_EN
        end else if (imem_ready) begin
          id_pc_4_d       = pcPlus4;
          id_instr_d      = imem_data;
          pending_valid_d = 1'b0;
          if (redirect)             pc_d = target;
          else if (pending_valid_q) pc_d = pending_target_q;
          else                      pc_d = pcPlus4;
        end else begin
          // Delay-slot fetch still outstanding: remember where to go once it lands.
          id_instr_d = NOP_WORD;
          if (redirect) begin
            pending_valid_d  = 1'b1;
            pending_target_d = target;
          end
        end
`else
        end else if (redirect) begin
          id_instr_d = NOP_WORD;
          pc_d       = target;
        end else if (imem_ready) begin
          id_pc_4_d  = pcPlus4;
          id_instr_d = imem_data;
          pc_d       = pcPlus4;
        end else begin
          id_instr_d = NOP_WORD;
        end
`endif
      end
      HOLD: begin
        if (!shouldStall) begin
          state_d = FETCH;
`ifdef IF_STAGE_DELAY_SLOT_EN
          id_pc_4_d       = hold_pc_4_q;
          id_instr_d      = hold_instr_q;
          pending_valid_d = 1'b0;
          if (redirect)             pc_d = target;
          else if (pending_valid_q) pc_d = pending_target_q;
          else                      pc_d = pcPlus4;
`else
          if (redirect) begin
            id_instr_d = NOP_WORD;
            pc_d       = target;
          end else begin
            id_pc_4_d  = hold_pc_4_q;
            id_instr_d = hold_instr_q;
            pc_d       = pcPlus4;
          end
`endif
        end
      end
      default: state_d = FETCH;
    endcase
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; expectations follow the build's
// IF_STAGE_DELAY_SLOT_EN setting.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        shouldStall;
  logic        shouldJumpOrBranch;
  logic [31:0] jumpOrBranchPc;
  logic        imem_request;
  logic [31:0] imem_address;
  logic        imem_ready;
  logic [31:0] imem_data;
  logic [31:0] id_pc_4;
  logic [31:0] id_instruction;
  logic [31:0] debug_pc;

  int checks   = 0;
  int failures = 0;

  if_stage dut (
    .clk(clk),
    .rst(rst),
    .shouldStall(shouldStall),
    .shouldJumpOrBranch(shouldJumpOrBranch),
    .jumpOrBranchPc(jumpOrBranchPc),
    .imem_request(imem_request),
    .imem_address(imem_address),
    .imem_ready(imem_ready),
    .imem_data(imem_data),
    .id_pc_4(id_pc_4),
    .id_instruction(id_instruction),
    .debug_pc(debug_pc)
  );

  // Memory model: each word holds its own address tagged with A in the top nibble.
  assign imem_data = imem_address | 32'hA000_0000;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    jumpOrBranchPc = 32'd0; imem_ready = 1'b1;
    tick(); tick();
    checks++; if (imem_request !== 1'b0) begin failures++; $display("[TB] FAIL reset_req got=%b exp=0", imem_request); end
    checks++; if (debug_pc !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc got=%h exp=%h", debug_pc, 32'h0); end
    checks++; if (id_instruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr got=%h exp=%h", id_instruction, 32'h0); end
    checks++; if (id_pc_4 !== 32'h0) begin failures++; $display("[TB] FAIL reset_pc4 got=%h exp=%h", id_pc_4, 32'h0); end
    rst = 1'b0;
    #1;
    checks++; if (imem_request !== 1'b1) begin failures++; $display("[TB] FAIL post_reset_req got=%b exp=1", imem_request); end
    checks++; if (imem_address !== 32'h0) begin failures++; $display("[TB] FAIL post_reset_addr got=%h exp=%h", imem_address, 32'h0); end
  endtask

  task automatic test_stream();
    logic [31:0] expInstr [3];
    logic [31:0] expPc4 [3];
    expInstr = '{32'hA000_0000, 32'hA000_0004, 32'hA000_0008};
    expPc4   = '{32'h4, 32'h8, 32'hC};
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (id_instruction !== expInstr[i]) begin failures++; $display("[TB] FAIL stream_instr%0d got=%h exp=%h", i, id_instruction, expInstr[i]); end
      checks++; if (id_pc_4 !== expPc4[i]) begin failures++; $display("[TB] FAIL stream_pc4%0d got=%h exp=%h", i, id_pc_4, expPc4[i]); end
    end
  endtask

  task automatic test_stall();
    tick();
    checks++; if (debug_pc !== 32'h10) begin failures++; $display("[TB] FAIL stall_start_pc got=%h exp=%h", debug_pc, 32'h10); end
    shouldStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      // A redirect while stalled must be ignored.
      shouldJumpOrBranch = (i == 1);
      jumpOrBranchPc = 32'h80;
      tick();
      checks++; if (imem_request !== 1'b0) begin failures++; $display("[TB] FAIL stall_req%0d got=%b exp=0", i, imem_request); end
      checks++; if (id_instruction !== 32'hA000_000C) begin failures++; $display("[TB] FAIL stall_instr%0d got=%h exp=%h", i, id_instruction, 32'hA000_000C); end
      checks++; if (debug_pc !== 32'h10) begin failures++; $display("[TB] FAIL stall_pc%0d got=%h exp=%h", i, debug_pc, 32'h10); end
    end
    shouldStall = 1'b0; shouldJumpOrBranch = 1'b0;
    tick();
    checks++; if (id_instruction !== 32'hA000_0010) begin failures++; $display("[TB] FAIL release_instr got=%h exp=%h", id_instruction, 32'hA000_0010); end
    checks++; if (id_pc_4 !== 32'h14) begin failures++; $display("[TB] FAIL release_pc4 got=%h exp=%h", id_pc_4, 32'h14); end
    checks++; if (imem_request !== 1'b1) begin failures++; $display("[TB] FAIL release_req got=%b exp=1", imem_request); end
    tick();
    checks++; if (id_instruction !== 32'hA000_0014) begin failures++; $display("[TB] FAIL after_release_instr got=%h exp=%h", id_instruction, 32'hA000_0014); end
  endtask

  task automatic test_not_ready();
    imem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (id_instruction !== 32'h0) begin failures++; $display("[TB] FAIL bubble_instr%0d got=%h exp=%h", i, id_instruction, 32'h0); end
      checks++; if (id_pc_4 !== 32'h18) begin failures++; $display("[TB] FAIL bubble_pc4%0d got=%h exp=%h", i, id_pc_4, 32'h18); end
      checks++; if (imem_address !== 32'h18) begin failures++; $display("[TB] FAIL bubble_addr%0d got=%h exp=%h", i, imem_address, 32'h18); end
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (id_instruction !== 32'hA000_0018) begin failures++; $display("[TB] FAIL bubble_done got=%h exp=%h", id_instruction, 32'hA000_0018); end
  endtask

  task automatic test_branch();
    logic [31:0] slotInstr, slotPc4;
`ifdef IF_STAGE_DELAY_SLOT_EN
    slotInstr = 32'hA000_001C; slotPc4 = 32'h20;
`else
    slotInstr = 32'h0; slotPc4 = 32'h1C;
`endif
    // Low target bits set on purpose: they must be dropped.
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h43;
    tick();
    shouldJumpOrBranch = 1'b0;
    checks++; if (id_instruction !== slotInstr) begin failures++; $display("[TB] FAIL branch_slot got=%h exp=%h", id_instruction, slotInstr); end
    checks++; if (id_pc_4 !== slotPc4) begin failures++; $display("[TB] FAIL branch_slot_pc4 got=%h exp=%h", id_pc_4, slotPc4); end
    checks++; if (imem_address !== 32'h40) begin failures++; $display("[TB] FAIL branch_addr got=%h exp=%h", imem_address, 32'h40); end
    tick();
    checks++; if (id_instruction !== 32'hA000_0040) begin failures++; $display("[TB] FAIL branch_target got=%h exp=%h", id_instruction, 32'hA000_0040); end
    checks++; if (id_pc_4 !== 32'h44) begin failures++; $display("[TB] FAIL branch_target_pc4 got=%h exp=%h", id_pc_4, 32'h44); end
  endtask

  task automatic test_branch_not_ready();
    logic [31:0] waitAddr, landInstr, landPc4, nextInstr;
`ifdef IF_STAGE_DELAY_SLOT_EN
    waitAddr = 32'h44; landInstr = 32'hA000_0044; landPc4 = 32'h48; nextInstr = 32'hA000_0080;
`else
    waitAddr = 32'h80; landInstr = 32'hA000_0080; landPc4 = 32'h84; nextInstr = 32'hA000_0084;
`endif
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h80; imem_ready = 1'b0;
    tick();
    shouldJumpOrBranch = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_address !== waitAddr) begin failures++; $display("[TB] FAIL pend_addr%0d got=%h exp=%h", i, imem_address, waitAddr); end
      checks++; if (id_instruction !== 32'h0) begin failures++; $display("[TB] FAIL pend_instr%0d got=%h exp=%h", i, id_instruction, 32'h0); end
`ifdef IF_STAGE_DELAY_SLOT_EN
      checks++; if (dut.pending_valid_q !== 1'b1) begin failures++; $display("[TB] FAIL pend_valid%0d got=%b exp=1", i, dut.pending_valid_q); end
`endif
      if (i == 0) tick();
    end
    imem_ready = 1'b1;
    tick();
    checks++; if (id_instruction !== landInstr) begin failures++; $display("[TB] FAIL pend_land got=%h exp=%h", id_instruction, landInstr); end
    checks++; if (id_pc_4 !== landPc4) begin failures++; $display("[TB] FAIL pend_land_pc4 got=%h exp=%h", id_pc_4, landPc4); end
`ifdef IF_STAGE_DELAY_SLOT_EN
    checks++; if (imem_address !== 32'h80) begin failures++; $display("[TB] FAIL pend_retarget got=%h exp=%h", imem_address, 32'h80); end
    checks++; if (dut.pending_valid_q !== 1'b0) begin failures++; $display("[TB] FAIL pend_clear got=%b exp=0", dut.pending_valid_q); end
`endif
    tick();
    checks++; if (id_instruction !== nextInstr) begin failures++; $display("[TB] FAIL pend_next got=%h exp=%h", id_instruction, nextInstr); end
  endtask

  task automatic test_reset_in_hold();
    shouldJumpOrBranch = 1'b1; jumpOrBranchPc = 32'h100; imem_ready = 1'b0;
    tick();
    shouldJumpOrBranch = 1'b0; shouldStall = 1'b1; imem_ready = 1'b1;
    tick();
    checks++; if (imem_request !== 1'b0) begin failures++; $display("[TB] FAIL hold_entry_req got=%b exp=0", imem_request); end
    rst = 1'b1;
    tick();
    rst = 1'b0; shouldStall = 1'b0;
    #1;
    checks++; if (debug_pc !== 32'h0) begin failures++; $display("[TB] FAIL rst_hold_pc got=%h exp=%h", debug_pc, 32'h0); end
    checks++; if (id_instruction !== 32'h0) begin failures++; $display("[TB] FAIL rst_hold_instr got=%h exp=%h", id_instruction, 32'h0); end
    checks++; if (id_pc_4 !== 32'h0) begin failures++; $display("[TB] FAIL rst_hold_pc4 got=%h exp=%h", id_pc_4, 32'h0); end
    checks++; if (imem_request !== 1'b1) begin failures++; $display("[TB] FAIL rst_hold_req got=%b exp=1", imem_request); end
`ifdef IF_STAGE_DELAY_SLOT_EN
    checks++; if (dut.pending_valid_q !== 1'b0) begin failures++; $display("[TB] FAIL rst_hold_pending got=%b exp=0", dut.pending_valid_q); end
`endif
    tick();
    checks++; if (id_instruction !== 32'hA000_0000) begin failures++; $display("[TB] FAIL rst_hold_refetch got=%h exp=%h", id_instruction, 32'hA000_0000); end
    checks++; if (id_pc_4 !== 32'h4) begin failures++; $display("[TB] FAIL rst_hold_refetch_pc4 got=%h exp=%h", id_pc_4, 32'h4); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_not_ready();
    test_branch();
    test_branch_not_ready();
    test_reset_in_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
